// File: rtl/clp_pkg.sv
// Constants and state encoding shared by the CLP instruction dispatcher and
// the layer controller it feeds.
package clp_pkg;

    localparam int CLP_INST_WIDTH = 100;
    localparam int CLP_OPCODE_LSB = 0;
    localparam int CLP_OPCODE_MSB = 3;
    localparam logic [3:0] CLP_HALT_OPCODE = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_CAPTURE   = 4'd2,
        ST_ISSUE     = 4'd3,
        ST_WAIT_ACK  = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_NEXT      = 4'd6,
        ST_FINISH    = 4'd7,
        ST_ERR       = 4'd8
    } disp_state_e;

endpackage

// File: rtl/clp_inst_dispatcher.sv
// Fetches layer instructions from instruction RAM and issues them one at a
// time to the CLP layer controller, following its enable/busy handshake.
module clp_inst_dispatcher
    import clp_pkg::*;
#(
    parameter int         INST_WIDTH      = CLP_INST_WIDTH,
    parameter int         INST_ADDR_WIDTH = 8,
    parameter int         ACK_TIMEOUT     = 4,
    parameter logic [3:0] HALT_OPCODE     = CLP_HALT_OPCODE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [INST_ADDR_WIDTH-1:0] inst_base_addr,
    input  logic [INST_ADDR_WIDTH-1:0] inst_count,
    output logic                       inst_rd_en,
    output logic [INST_ADDR_WIDTH-1:0] inst_rd_addr,
    input  logic [INST_WIDTH-1:0]      inst_rd_data,
    output logic                       clp_enable,
    output logic [INST_WIDTH-1:0]      clp_instruction,
    input  logic                       clp_state,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [INST_ADDR_WIDTH-1:0] cur_index
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [INST_ADDR_WIDTH-1:0] IDX_ONE = INST_ADDR_WIDTH'(1);

    disp_state_e                state_r;
    logic [INST_ADDR_WIDTH-1:0] base_r;
    logic [INST_ADDR_WIDTH-1:0] count_r;
    logic [TMO_W-1:0]           tmo_cnt_r;
    logic [INST_ADDR_WIDTH-1:0] idx_inc_s;
    logic                       halt_s;

    assign idx_inc_s = cur_index + IDX_ONE;
    assign halt_s    = (inst_rd_data[CLP_OPCODE_MSB:CLP_OPCODE_LSB] == HALT_OPCODE);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            base_r          <= '0;
            count_r         <= '0;
            tmo_cnt_r       <= '0;
            inst_rd_en      <= 1'b0;
            inst_rd_addr    <= '0;
            clp_enable      <= 1'b0;
            clp_instruction <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            cur_index       <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        if (inst_count == '0) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_FINISH;
                        end else begin
                            base_r       <= inst_base_addr;
                            count_r      <= inst_count;
                            cur_index    <= '0;
                            error        <= 1'b0;
                            busy         <= 1'b1;
                            inst_rd_en   <= 1'b1;
                            inst_rd_addr <= inst_base_addr;
                            state_r      <= ST_FETCH;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FETCH: begin
                    inst_rd_en <= 1'b0;
                    state_r    <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // A halt word ends the program and never reaches the controller bus.
                    if (halt_s) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_FINISH;
                    end else begin
                        clp_instruction <= inst_rd_data;
                        clp_enable      <= 1'b1;
                        state_r         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    clp_enable <= 1'b0;
                    tmo_cnt_r  <= '0;
                    state_r    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (clp_state) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_ERR;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!clp_state) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_NEXT: begin
                    if (idx_inc_s == count_r) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_FINISH;
                    end else begin
                        cur_index    <= idx_inc_s;
                        inst_rd_en   <= 1'b1;
                        inst_rd_addr <= base_r + idx_inc_s;
                        state_r      <= ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    inst_rd_en <= 1'b0;
                    clp_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clp_inst_dispatcher.sv
// Directed and randomized programs for clp_inst_dispatcher, checked against
// a cycle-level expectation computed from the sequencing rules.
module tb_clp_inst_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  inst_base_addr = 8'h00;
    logic [7:0]  inst_count = 8'h00;
    logic        inst_rd_en;
    logic [7:0]  inst_rd_addr;
    logic [99:0] inst_rd_data;
    logic        clp_enable;
    logic [99:0] clp_instruction;
    logic        clp_state;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  cur_index;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    clp_inst_dispatcher #(
        .INST_WIDTH(100), .INST_ADDR_WIDTH(8), .ACK_TIMEOUT(4), .HALT_OPCODE(4'hF)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .inst_base_addr(inst_base_addr), .inst_count(inst_count),
        .inst_rd_en(inst_rd_en), .inst_rd_addr(inst_rd_addr), .inst_rd_data(inst_rd_data),
        .clp_enable(clp_enable), .clp_instruction(clp_instruction), .clp_state(clp_state),
        .busy(busy), .done(done), .error(error), .cur_index(cur_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read instruction RAM.
    logic [99:0] mem [256];
    always @(posedge clk) begin
        if (inst_rd_en) inst_rd_data <= mem[inst_rd_addr];
    end

    // Layer controller model: busy for ctl_run_len cycles after each enable.
    int ctl_run_len = 1;
    bit ctl_noack = 1'b0;
    int run_left;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clp_state <= 1'b0;
            run_left  <= 0;
        end else if (clp_enable && !ctl_noack) begin
            clp_state <= 1'b1;
            run_left  <= ctl_run_len - 1;
        end else if (run_left != 0) begin
            run_left <= run_left - 1;
        end else begin
            clp_state <= 1'b0;
        end
    end

    // Event log of DUT activity plus instruction-bus stability watch.
    int          rd_cyc_q[$];
    logic [7:0]  rd_addr_q[$];
    int          en_cyc_q[$];
    logic [99:0] en_inst_q[$];
    int          done_cyc_q[$];
    logic [99:0] ctl_inst;
    int          unstable_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_rd_en) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(inst_rd_addr);
            end
            if (clp_enable) begin
                en_cyc_q.push_back(cyc);
                en_inst_q.push_back(clp_instruction);
                ctl_inst <= clp_instruction;
            end
            if (done) done_cyc_q.push_back(cyc);
            if (clp_state && (clp_instruction !== ctl_inst)) unstable_cnt <= unstable_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] rand_inst();
        logic [127:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (w[3:0] == 4'hF) w[3:0] = 4'h1;
        return w[99:0];
    endfunction

    logic [99:0] model_inst = '0;
    logic [7:0]  model_idx  = '0;

    // Runs one program and checks every read, issue, done and final state.
    task automatic run_prog(input string tag, input logic [7:0] base, input logic [7:0] cnt,
                            input int run, input int poke);
        int t0, f, exp_done, budget, rp, ep, dp;
        logic [7:0] addr;
        int          x_rd_cyc[$];
        logic [7:0]  x_rd_addr[$];
        int          x_en_cyc[$];
        logic [99:0] x_en_inst[$];
        rp = rd_addr_q.size();
        ep = en_cyc_q.size();
        dp = done_cyc_q.size();
        ctl_run_len = run;
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        inst_base_addr = base;
        inst_count = cnt;
        // Expected timeline: fetch f, issue f+2, next fetch f+run+5.
        exp_done = t0 + 1;
        f = t0 + 1;
        for (int i = 0; i < int'(cnt); i++) begin
            addr = base + 8'(i);
            x_rd_cyc.push_back(f);
            x_rd_addr.push_back(addr);
            model_idx = 8'(i);
            if (mem[addr][3:0] == 4'hF) begin
                exp_done = f + 2;
                break;
            end
            x_en_cyc.push_back(f + 2);
            x_en_inst.push_back(mem[addr]);
            model_inst = mem[addr];
            exp_done = f + run + 5;
            f = f + run + 5;
        end
        budget = int'(cnt) * (run + 10) + 20;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            start = (poke != 0 && cyc == t0 + poke);
            if (poke != 0 && cyc == t0 + poke) begin
                inst_base_addr = base + 8'h40;
                inst_count = 8'd1;
            end
            if (done_cyc_q.size() > dp) break;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " done_count"}, done_cyc_q.size() - dp, 1);
        if (done_cyc_q.size() > dp) check({tag, " done_cycle"}, done_cyc_q[dp], exp_done);
        check({tag, " rd_count"}, rd_addr_q.size() - rp, x_rd_addr.size());
        for (int k = 0; k < x_rd_addr.size() && rp + k < rd_addr_q.size(); k++) begin
            check($sformatf("%s rd_addr[%0d]", tag, k), rd_addr_q[rp + k], x_rd_addr[k]);
            check($sformatf("%s rd_cycle[%0d]", tag, k), rd_cyc_q[rp + k], x_rd_cyc[k]);
        end
        check({tag, " en_count"}, en_cyc_q.size() - ep, x_en_cyc.size());
        for (int k = 0; k < x_en_cyc.size() && ep + k < en_cyc_q.size(); k++) begin
            check($sformatf("%s en_cycle[%0d]", tag, k), en_cyc_q[ep + k], x_en_cyc[k]);
            check($sformatf("%s en_inst[%0d]", tag, k), en_inst_q[ep + k], x_en_inst[k]);
        end
        check({tag, " busy_after"}, busy, 1'b0);
        check({tag, " error_after"}, error, 1'b0);
        check({tag, " instr_held"}, clp_instruction, model_inst);
        if (cnt != 8'd0) check({tag, " cur_index"}, cur_index, model_idx);
        check({tag, " bus_stable"}, unstable_cnt, 0);
    endtask

    initial begin
        int t0, err_cyc, ep, dp;
        for (int i = 0; i < 256; i++) mem[i] = rand_inst();

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst error", error, 1'b0);
        check("rst rd_en", inst_rd_en, 1'b0);
        check("rst enable", clp_enable, 1'b0);
        check("rst instr", clp_instruction, 100'd0);
        check("rst index", cur_index, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        run_prog("long", 8'h10, 8'd2, 788, 0);
        run_prog("empty", 8'h55, 8'd0, 3, 0);

        mem[8'h21][3:0] = 4'hF;
        run_prog("halt", 8'h20, 8'd3, 5, 0);
        mem[8'h21][3:0] = 4'h2;

        // Controller that never acknowledges.
        ctl_noack = 1'b1;
        ep = en_cyc_q.size();
        dp = done_cyc_q.size();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        inst_base_addr = 8'h30;
        inst_count = 8'd2;
        @(negedge clk);
        start = 1'b0;
        err_cyc = -1;
        for (int k = 0; k < 30; k++) begin
            if (error === 1'b1) begin
                err_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("noack err_cycle", err_cyc, t0 + 8);
        check("noack busy", busy, 1'b0);
        check("noack en_count", en_cyc_q.size() - ep, 1);
        if (en_cyc_q.size() > ep) check("noack en_cycle", en_cyc_q[ep], t0 + 3);
        repeat (5) @(negedge clk);
        check("noack sticky", error, 1'b1);
        check("noack no_done", done_cyc_q.size() - dp, 0);
        model_inst = mem[8'h30];
        ctl_noack = 1'b0;
        run_prog("recover", 8'h40, 8'd2, 6, 0);

        run_prog("poke", 8'h60, 8'd2, 30, 15);

        for (int r = 0; r < 4; r++) begin
            run_prog($sformatf("rand%0d", r), 8'($urandom_range(0, 255)),
                     8'($urandom_range(1, 4)), $urandom_range(1, 20), 0);
        end

        // Asynchronous reset in the middle of a layer.
        ctl_run_len = 50;
        @(negedge clk);
        start = 1'b1;
        inst_base_addr = 8'h05;
        inst_count = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst error", error, 1'b0);
        check("midrst rd_en", inst_rd_en, 1'b0);
        check("midrst rd_addr", inst_rd_addr, 8'h00);
        check("midrst instr", clp_instruction, 100'd0);
        check("midrst index", cur_index, 8'd0);
        check("midrst enable", clp_enable, 1'b0);
        check("midrst done", done, 1'b0);
        model_inst = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_prog("wrap", 8'hFF, 8'd2, 7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
